// File: rtl/mac_tile_mp.sv
// Multi-precision weight-stationary MAC tile: activations and instructions flow
// west->east, psum flows north->south, weights are loaded by a small FSM.
module mac_tile_mp #(
   parameter int bw      = 4,
   parameter int wbw     = 4,
   parameter int psum_bw = 16,
   parameter int NLANE   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mode,
   input  logic [bw-1:0]      in_w,
   input  logic [2:0]         inst_w,
   input  logic [psum_bw-1:0] in_n,
   output logic [bw-1:0]      out_e,
   output logic [2:0]         inst_e,
   output logic [psum_bw-1:0] out_s
);

   localparam int lw = bw / NLANE;
   localparam int CW = $clog2(NLANE + 1);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 mode_q, mode_d;
   logic [bw-1:0]        a_q, a_d;
   logic [psum_bw-1:0]   c_q, c_d;
   logic [2:0]           inst_q, inst_d;
   logic [wbw-1:0]       w_q [NLANE];
   logic [wbw-1:0]       w_d [NLANE];

   // Unsigned activation times signed weight, wrapped to psum_bw bits.
   function automatic logic [psum_bw-1:0] mul_term(input logic [bw-1:0] a,
                                                   input logic [wbw-1:0] w);
      logic [psum_bw-1:0] ae;
      logic [psum_bw-1:0] we;
      ae = psum_bw'(a);
      we = psum_bw'($signed(w));
      return ae * we;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      w_d       = w_q;
      c_d       = in_n;
      a_d       = (inst_w[0] | inst_w[1]) ? in_w : a_q;
      inst_d[0] = 1'b0;
      inst_d[1] = inst_w[1];
      inst_d[2] = inst_w[2];
      if (inst_w[2]) begin
         state_d = EMPTY;
         cnt_d   = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (inst_w[0]) begin
                  mode_d = mode;
                  w_d[0] = in_w[wbw-1:0];
                  if (!mode) begin
                     for (int k = 0; k < NLANE; k++) w_d[k] = in_w[wbw-1:0];
                     state_d = FULL;
                  end else begin
                     cnt_d   = CW'(1);
                     state_d = PARTIAL;
                  end
               end
            end
            PARTIAL: begin
               if (inst_w[0]) begin
                  for (int k = 0; k < NLANE; k++)
                     if (cnt_q == CW'(k)) w_d[k] = in_w[wbw-1:0];
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_q + CW'(1) == CW'(NLANE)) state_d = FULL;
               end
            end
            FULL: inst_d[0] = inst_w[0];
            default: state_d = EMPTY;
         endcase
      end
   end

   // Single register stage per tile
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         a_q     <= '0;
         c_q     <= '0;
         inst_q  <= '0;
         for (int k = 0; k < NLANE; k++) w_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         a_q     <= a_d;
         c_q     <= c_d;
         inst_q  <= inst_d;
         w_q     <= w_d;
      end
   end

   always_comb begin
      out_s = c_q;
      if (!mode_q) begin
         out_s = out_s + mul_term(a_q, w_q[0]);
      end else begin
         for (int k = 0; k < NLANE; k++)
            out_s = out_s + mul_term(bw'(a_q[k*lw +: lw]), w_q[k]);
      end
   end

   assign out_e  = a_q;
   assign inst_e = inst_q;

endmodule

// File: tb/tb_mac_tile_mp.sv
// Self-checking bench for mac_tile_mp (bw=4, wbw=4, psum_bw=16, NLANE=2):
// directed scenarios followed by randomized traffic against a behavioural model.
module tb_mac_tile_mp;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mode = 1'b0;
   logic [3:0]  in_w = '0;
   logic [2:0]  inst_w = '0;
   logic [15:0] in_n = '0;
   logic [3:0]  out_e;
   logic [2:0]  inst_e;
   logic [15:0] out_s;

   int n_cmp = 0;
   int n_err = 0;

   mac_tile_mp #(.bw(4), .wbw(4), .psum_bw(16), .NLANE(2)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .inst_w(inst_w),
      .in_n(in_n), .out_e(out_e), .inst_e(inst_e), .out_s(out_s)
   );

   always #5 clk = ~clk;

   // Behavioural model: list of captured weights plus a "full" flag
   int       m_a, m_c, m_inst, m_mode, m_nload;
   bit       m_full;
   int       m_w [2];

   function automatic int sw(input int w);
      return (w >= 8) ? w - 16 : w;
   endfunction

   function automatic int model_out_s();
      int acc;
      acc = m_c;
      if (m_mode == 0) acc += m_a * sw(m_w[0]);
      else for (int k = 0; k < 2; k++) acc += ((m_a >> (2 * k)) & 3) * sw(m_w[k]);
      return acc & 16'hFFFF;
   endfunction

   task automatic model_edge(input int w, input int ins, input int n, input int md,
                             input bit rst);
      if (rst) begin
         m_a = 0; m_c = 0; m_inst = 0; m_mode = 0; m_nload = 0; m_full = 0;
         m_w[0] = 0; m_w[1] = 0;
         return;
      end
      m_inst = (ins & 6) | ((((ins & 4) == 0) && m_full) ? (ins & 1) : 0);
      if (ins & 3) m_a = w;
      m_c = n;
      if (ins & 4) begin
         m_full = 0; m_nload = 0;
      end else if ((ins & 1) && !m_full) begin
         if (m_nload == 0) m_mode = md;
         m_w[m_nload] = w;
         m_nload++;
         if (m_mode == 0) begin
            m_w[1] = w; m_full = 1;
         end else if (m_nload == 2) m_full = 1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [3:0] w, input logic [2:0] ins, input logic [15:0] n,
                       input logic md, input logic rst);
      in_w = w; inst_w = ins; in_n = n; mode = md; reset = rst;
      @(posedge clk);
      model_edge(int'(w), int'(ins), int'(n), int'(md), rst);
      #1;
      check("out_e", 32'(out_e), 32'(m_a));
      check("inst_e", 32'(inst_e), 32'(m_inst));
      check("out_s", 32'(out_s), 32'(model_out_s()));
   endtask

   initial begin
      model_edge(0, 0, 0, 0, 1'b1);
      // 1: reset
      step(4'h0, 3'b000, 16'h0, 1'b0, 1'b1);
      step(4'h0, 3'b000, 16'h0, 1'b0, 1'b1);
      check("t1_out_e", 32'(out_e), 32'h0);
      check("t1_inst_e", 32'(inst_e), 32'h0);
      check("t1_out_s", 32'(out_s), 32'h0);
      // 2: mode 0 single weight
      step(4'hD, 3'b001, 16'h0, 1'b0, 1'b0);
      check("t2_inst_e0", 32'(inst_e[0]), 32'h0);
      step(4'h5, 3'b010, 16'd10, 1'b0, 1'b0);
      check("t2_out_s", 32'(out_s), 32'hFFFB);
      // 3: mode 1 two lanes
      step(4'h0, 3'b100, 16'h0, 1'b1, 1'b0);
      step(4'h3, 3'b001, 16'h0, 1'b1, 1'b0);
      step(4'hE, 3'b001, 16'h0, 1'b1, 1'b0);
      step(4'b1001, 3'b010, 16'h0, 1'b1, 1'b0);
      check("t3_out_s", 32'(out_s), 32'hFFFF);
      // 4: third load passes east
      step(4'h0, 3'b100, 16'h0, 1'b1, 1'b0);
      step(4'h1, 3'b001, 16'h0, 1'b1, 1'b0);
      check("t4_inst_e0_a", 32'(inst_e[0]), 32'h0);
      step(4'h2, 3'b001, 16'h0, 1'b1, 1'b0);
      check("t4_inst_e0_b", 32'(inst_e[0]), 32'h0);
      step(4'h7, 3'b001, 16'h0, 1'b1, 1'b0);
      check("t4_inst_e0_c", 32'(inst_e[0]), 32'h1);
      check("t4_out_e", 32'(out_e), 32'h7);
      step(4'b0101, 3'b010, 16'h0, 1'b1, 1'b0);
      check("t4_weights", 32'(out_s), 32'd3);
      // 5: rearm beats load
      step(4'h9, 3'b101, 16'h0, 1'b1, 1'b0);
      check("t5_inst_e", 32'(inst_e), 32'b100);
      step(4'h2, 3'b001, 16'h0, 1'b0, 1'b0);
      step(4'h3, 3'b010, 16'h0, 1'b0, 1'b0);
      check("t5_out_s", 32'(out_s), 32'd6);
      // 6: wrap
      step(4'h0, 3'b100, 16'h0, 1'b0, 1'b0);
      step(4'h1, 3'b001, 16'h0, 1'b0, 1'b0);
      step(4'h3, 3'b010, 16'h7FFF, 1'b0, 1'b0);
      check("t6_out_s", 32'(out_s), 32'h8002);
      // 7: reset mid-load restarts at lane 0
      step(4'h0, 3'b100, 16'h0, 1'b1, 1'b0);
      step(4'h1, 3'b001, 16'h0, 1'b1, 1'b0);
      step(4'h0, 3'b000, 16'h0, 1'b1, 1'b1);
      step(4'h1, 3'b001, 16'h0, 1'b1, 1'b0);
      step(4'h1, 3'b001, 16'h0, 1'b1, 1'b0);
      step(4'b0101, 3'b010, 16'h0, 1'b1, 1'b0);
      check("t7_out_s", 32'(out_s), 32'd2);
      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [2:0] ins;
         ins = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 5) != 0) ins[2] = 1'b0;
         step(4'($urandom), ins, 16'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
